ddr_port_arbiter: RTL
=====================

Name: ddr_port_arbiter

Overview:
- Parametrised N-channel front-end for the drac_ddr3 simple system port (srd/swr/sa/swdat/smsk/srdat/srdy).
- Replaces the tied-off mem_rd/mem_wr/mem_addr/mem_wrdat/mem_mask wiring in bridge, so the CPU, PCI and LIMB paths can each issue 256-bit memory transactions.
- Round-robin arbitration, one outstanding transaction at a time, and a watchdog timeout that returns an error instead of hanging a requester.

Parameters:
NCH, 3, number of requester channels (1..8)
AW, 29, memory address width (drac sa)
DW, 256, data width (drac swdat/srdat)
MW, 32, byte-mask width; must equal DW/8
TIMEOUT, 1024, max WAIT cycles before error; 0 disables the timeout
CW, 11, timeout counter width; must satisfy 2^CW > TIMEOUT

Ports:
ck  in  1  system clock (drac ckouthalf domain); all logic on the rising edge
reset  in  1  synchronous, active-high reset
ch_req  in  NCH  per-channel request level
ch_wr  in  NCH  1 = write, 0 = read
ch_addr  in  NCH*AW  packed addresses; channel i at [i*AW +: AW]
ch_wdat  in  NCH*DW  packed write data
ch_mask  in  NCH*MW  packed byte masks, passed through unmodified
ch_ack  out  NCH  one-cycle completion pulse to the granted channel
ch_err  out  1  valid with ch_ack; 1 = timeout
ch_rdat  out  DW  read data, valid with ch_ack on reads
busy  out  1  high whenever the state is not IDLE
grant  out  3  index of the current or last granted channel
mem_rd  out  1  to drac srd
mem_wr  out  1  to drac swr
mem_addr  out  AW  to drac sa
mem_wrdat  out  DW  to drac swdat
mem_mask  out  MW  to drac smsk
mem_rdat  in  DW  from drac srdat
mem_rdy  in  1  from drac srdy

Behaviour:
- Reset: every output is 0; state = IDLE; round-robin pointer ptr = 0; timeout counter = 0. Reset asserted in any state aborts the transaction in progress and produces no ack.
- Requester rules: hold ch_req[i] and its fields stable until ch_ack[i]. If ch_req drops early, the transaction still completes and ch_ack still pulses.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: if any ch_req bit is set, grant the first set index searching ptr, ptr+1, ... modulo NCH. Latch wr/addr/wdat/mask of that channel, set grant, go to ISSUE. If no bit is set, stay in IDLE.
- ISSUE: drive mem_rd = ~wr or mem_wr = wr high for exactly one cycle; clear the counter; go to WAIT.
- mem_addr/mem_wrdat/mem_mask are registered from the latch and held stable from ISSUE through DONE.
- WAIT: mem_rd and mem_wr are 0.
  - On mem_rdy: latch mem_rdat (reads only), err = 0, go to DONE.
  - Otherwise, if TIMEOUT != 0 and counter == TIMEOUT-1: err = 1, rdat = 0, go to DONE.
  - Otherwise: counter += 1.
  - mem_rdy and timeout in the same cycle: mem_rdy wins.
- DONE: ch_ack[grant] = 1 and ch_err = err for exactly one cycle; ch_rdat holds its value until the next DONE. Set ptr = (grant+1) mod NCH, go to IDLE.
- mem_rdy is sampled only in WAIT; it is ignored in IDLE, ISSUE and DONE. A late srdy after a timeout is therefore dropped.
- Latency: if req rises in cycle 0 and mem_rdy arrives in cycle k (k >= 2), then mem_rd/mem_wr pulse in cycle 1 and ch_ack pulses in cycle k+1. Minimum 3 cycles request-to-ack.
- Back-to-back: a channel requesting in the DONE cycle is considered in the following IDLE cycle. There is one idle cycle between transactions.
- Fairness: with all channels requesting continuously, grants rotate 0,1,..,NCH-1,0 with no starvation.
- NCH = 1: ptr stays 0 and grant stays 0.

Test Plan:
- Single read: ch0 reads addr 29'h0000100; drac model returns srdy 5 cycles after srd with srdat = {8{32'hDEADBEEF}} -> mem_rd single pulse in cycle 1, ch_ack = 3'b001 in cycle 7, ch_err = 0, ch_rdat matches.
- Masked write: ch2 writes addr 29'h1FFFFFFF, mask 32'h0000FFFF -> mem_wr single pulse; mem_addr, mem_wrdat and mem_mask equal the ch2 fields; ch_ack = 3'b100 one cycle after srdy.
- Round-robin: all three channels request continuously with srdy fixed at 2 cycles -> grant sequence 0,1,2,0,1,2; each ack 4 cycles apart.
- Timeout: TIMEOUT = 16 and srdy never asserted -> ch_ack with ch_err = 1 and ch_rdat = 0 in cycle 18. A subsequent srdy in IDLE is ignored and the next request proceeds normally.
- Boundary: srdy on exactly the 16th WAIT cycle (TIMEOUT = 16) -> ch_err = 0. Separately, srdy pulsed during ISSUE -> ignored and the block stays in WAIT.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> no ch_ack, all outputs 0 in the next cycle, ptr = 0; a new ch1 request is granted normally.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// Round-robin N-channel front-end for the drac_ddr3 simple port: one transaction
// in flight, single-cycle srd/swr strobe, and a WAIT watchdog that completes with an error.
module ddr_port_arbiter #(
    parameter int NCH     = 3,
    parameter int AW      = 29,
    parameter int DW      = 256,
    parameter int MW      = 32,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 11
) (
    input  logic              ck,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_wr,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdat,
    input  logic [NCH*MW-1:0] ch_mask,
    output logic [NCH-1:0]    ch_ack,
    output logic              ch_err,
    output logic [DW-1:0]     ch_rdat,
    output logic              busy,
    output logic [2:0]        grant,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wrdat,
    output logic [MW-1:0]     mem_mask,
    input  logic [DW-1:0]     mem_rdat,
    input  logic              mem_rdy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic [MW-1:0]   mask_q, mask_d;
    logic [DW-1:0]   rdat_q, rdat_d;

    // Per-channel views padded to 8 entries so a 3-bit grant indexes them exactly.
    logic [7:0]      wr_arr;
    logic [AW-1:0]   addr_arr [8];
    logic [DW-1:0]   wdat_arr [8];
    logic [MW-1:0]   mask_arr [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
        if (gi < NCH) begin : g_used
            assign wr_arr[gi]   = ch_wr[gi];
            assign addr_arr[gi] = ch_addr[gi*AW +: AW];
            assign wdat_arr[gi] = ch_wdat[gi*DW +: DW];
            assign mask_arr[gi] = ch_mask[gi*MW +: MW];
        end else begin : g_pad
            assign wr_arr[gi]   = 1'b0;
            assign addr_arr[gi] = '0;
            assign wdat_arr[gi] = '0;
            assign mask_arr[gi] = '0;
        end
    end

    // Rotate requests so bit 0 is the channel at ptr; the lowest set bit wins.
    logic [2*NCH-1:0] req_rot;
    logic [2:0]       pick_off;
    logic [3:0]       pick_sum;
    logic [2:0]       pick_idx;

    assign req_rot = {ch_req, ch_req} >> ptr_q;

    always_comb begin
        pick_off = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = 3'(k);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
        if (pick_sum >= 4'(NCH)) begin
            pick_sum = pick_sum - 4'(NCH);
        end
        pick_idx = pick_sum[2:0];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        mask_d  = mask_q;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: begin
                if (|ch_req) begin
                    grant_d = pick_idx;
                    wr_d    = wr_arr[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    wdat_d  = wdat_arr[pick_idx];
                    mask_d  = mask_arr[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A ready in the same cycle as the timeout still counts as success.
                if (mem_rdy) begin
                    if (!wr_q) begin
                        rdat_d = mem_rdat;
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ptr_d   = (grant_q == 3'(NCH - 1)) ? 3'd0 : grant_q + 3'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            mask_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            mask_q  <= mask_d;
            rdat_q  <= rdat_d;
        end
    end

    assign mem_rd    = (state_q == ISSUE) && !wr_q;
    assign mem_wr    = (state_q == ISSUE) && wr_q;
    assign mem_addr  = addr_q;
    assign mem_wrdat = wdat_q;
    assign mem_mask  = mask_q;
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;
    assign ch_ack    = (state_q == DONE) ? (NCH'(1) << grant_q) : '0;
    assign ch_err    = (state_q == DONE) && err_q;
    assign ch_rdat   = rdat_q;

endmodule
